// File: rtl/pixel_collector.sv
// rtl/pixel_collector.sv - round-robin re-serialiser of per-core RGB pixels into one framed stream
// Optional statistics outputs are enabled by defining PIXEL_COLLECTOR_STATS_EN.
module pixel_collector #(
    parameter int NUM_CORES = 4,
    parameter int DEPTH     = 2,
    parameter int COLOR_W   = 8,
    parameter int FRAME_W   = 640,
    parameter int FRAME_H   = 480,
    localparam int AW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int PW = 3 * COLOR_W
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [AW-1:0]           active_cores,
    input  logic [NUM_CORES-1:0]    in_valid,
    output logic [NUM_CORES-1:0]    in_ready,
    input  logic [NUM_CORES*PW-1:0] in_pixel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PW-1:0]           out_data,
    output logic                    out_user,
    output logic                    out_last
`ifdef PIXEL_COLLECTOR_STATS_EN
    ,
    output logic [31:0]             stat_stall,
    output logic [31:0]             stat_starve,
    output logic [15:0]             stat_frames
`endif
);
    localparam int DW = $clog2(DEPTH);
    localparam int CW = DW + 1;
    localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

    typedef enum logic {RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [PW-1:0] mem [NUM_CORES][DEPTH];
    logic [DW-1:0] wr_idx [NUM_CORES];
    logic [DW-1:0] rd_idx [NUM_CORES];
    logic [CW-1:0] cnt    [NUM_CORES];

    logic [AW-1:0] a_lat, a_eff, ptr, ptr_nxt;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic          out_fend;
    logic          fifo_ne, pop, hs, boundary, pop_last;

    // px/py track the position of the next pixel to be popped; since output
    // order equals pop order, tags can be registered alongside the pixel.
    always_comb begin
        fifo_ne  = (cnt[ptr] != '0);
        pop      = fifo_ne && (!out_valid || out_ready);
        hs       = out_valid && out_ready;
        boundary = hs && out_fend;
        a_eff    = boundary ? active_cores : a_lat;
        pop_last = (px == XW'(FRAME_W - 1)) && (py == YW'(FRAME_H - 1));
        ptr_nxt  = ptr;
        if (pop)
            ptr_nxt = (ptr == a_eff || pop_last) ? '0 : ptr + AW'(1);
        else if (boundary)
            ptr_nxt = '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (boundary && active_cores != a_lat) state_nxt = DRAIN;
            DRAIN:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_CORES; i++)
            in_ready[i] = !areset && (state == RUN) && (AW'(i) <= a_lat) &&
                          (cnt[i] != CW'(DEPTH));
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < NUM_CORES; i++)
            if (in_valid[i] && in_ready[i])
                mem[i][wr_idx[i]] <= in_pixel[i*PW +: PW];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            a_lat     <= active_cores;
            ptr       <= '0;
            px        <= '0;
            py        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_user  <= 1'b0;
            out_last  <= 1'b0;
            out_fend  <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                wr_idx[i] <= '0;
                rd_idx[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            if (boundary) a_lat <= active_cores;
            ptr <= ptr_nxt;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (state == DRAIN && AW'(i) > a_lat) begin
                    wr_idx[i] <= '0;
                    rd_idx[i] <= '0;
                    cnt[i]    <= '0;
                end else begin
                    if (in_valid[i] && in_ready[i]) wr_idx[i] <= wr_idx[i] + DW'(1);
                    if (pop && ptr == AW'(i))      rd_idx[i] <= rd_idx[i] + DW'(1);
                    cnt[i] <= cnt[i] + CW'(in_valid[i] && in_ready[i])
                                     - CW'(pop && ptr == AW'(i));
                end
            end
            if (pop) begin
                out_valid <= 1'b1;
                out_data  <= mem[ptr][rd_idx[ptr]];
                out_user  <= (px == '0) && (py == '0);
                out_last  <= (px == XW'(FRAME_W - 1));
                out_fend  <= pop_last;
                if (px == XW'(FRAME_W - 1)) begin
                    px <= '0;
                    py <= (py == YW'(FRAME_H - 1)) ? '0 : py + YW'(1);
                end else begin
                    px <= px + XW'(1);
                end
            end else if (hs) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PIXEL_COLLECTOR_STATS_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            stat_stall  <= '0;
            stat_starve <= '0;
            stat_frames <= '0;
        end else begin
            if (out_valid && !out_ready) stat_stall  <= stat_stall + 32'd1;
            if (!out_valid && !fifo_ne)  stat_starve <= stat_starve + 32'd1;
            if (boundary)                stat_frames <= stat_frames + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_collector.sv
// tb/tb_pixel_collector.sv - scoreboard bench for pixel_collector (4 cores, 8x2 frames)
module tb_pixel_collector;
    localparam int NC = 4;
    localparam int DEPTH = 2;
    localparam int CWID = 8;
    localparam int FW = 8;
    localparam int FH = 2;
    localparam int PW = 3 * CWID;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [1:0]        active_cores = 2'd3;
    logic [NC-1:0]     in_valid = '0;
    logic [NC-1:0]     in_ready;
    logic [NC*PW-1:0]  in_pixel = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PW-1:0]     out_data;
    logic              out_user;
    logic              out_last;

    always #5 aclk = ~aclk;

    pixel_collector #(
        .NUM_CORES(NC), .DEPTH(DEPTH), .COLOR_W(CWID), .FRAME_W(FW), .FRAME_H(FH)
    ) dut (
        .aclk(aclk), .areset(areset), .active_cores(active_cores),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_user(out_user), .out_last(out_last)
    );

    logic [PW-1:0] q [NC][$];
    int seq [NC];
    int model_a, exp_core, mx, my, hs_cnt, drain_seen, checks, failures, first_v;
    bit drain_next, prev_stall, rand_ready, ready_fixed;
    logic [NC-1:0] withhold, act_mask;
    logic [PW-1:0] hold_d, exp_d;
    logic hold_u, hold_l;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix(input int i, input int s);
        return {i[7:0], s[7:0], s[15:8]};
    endfunction

    // One clock: drive at negedge, observe settled values, update the model for the coming edge.
    task automatic cycle();
        @(negedge aclk);
        for (int i = 0; i < NC; i++) begin
            in_valid[i] = !areset && !withhold[i];
            in_pixel[i*PW +: PW] = pix(i, seq[i]);
        end
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
        #1;
        if (!areset) begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_d);
                check("hold_user", out_user, hold_u);
                check("hold_last", out_last, hold_l);
            end
            if (drain_next) begin
                check("drain_in_ready", in_ready, 0);
                drain_seen++;
                drain_next = 0;
            end
            for (int i = 0; i < NC; i++) act_mask[i] = (i <= model_a);
            check("inactive_ready", in_ready & ~act_mask, 0);
            for (int i = 0; i < NC; i++)
                if (in_valid[i] && in_ready[i]) begin
                    q[i].push_back(pix(i, seq[i]));
                    seq[i]++;
                end
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(q[exp_core].size() != 0), 1);
                if (q[exp_core].size() != 0) begin
                    exp_d = q[exp_core].pop_front();
                    check("out_data", out_data, exp_d);
                end
                check("out_user", out_user, 32'(mx == 0 && my == 0));
                check("out_last", out_last, 32'(mx == FW - 1));
                hs_cnt++;
                if (mx == FW - 1 && my == FH - 1) begin
                    if (int'(active_cores) != model_a) begin
                        drain_next = 1;
                        for (int i = int'(active_cores) + 1; i < NC; i++) q[i].delete();
                    end
                    model_a = int'(active_cores);
                    exp_core = 0;
                    mx = 0;
                    my = 0;
                end else begin
                    exp_core = (exp_core == model_a) ? 0 : exp_core + 1;
                    if (mx == FW - 1) begin mx = 0; my++; end
                    else mx++;
                end
            end
            prev_stall = out_valid && !out_ready;
            hold_d = out_data;
            hold_u = out_user;
            hold_l = out_last;
        end
    endtask

    task automatic do_reset(input int a);
        areset = 1'b1;
        active_cores = 2'(a);
        cycle();
        check("rst_in_ready_0", in_ready, 0);
        cycle();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_user", out_user, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready_1", in_ready, 0);
        for (int i = 0; i < NC; i++) q[i].delete();
        model_a = a; exp_core = 0; mx = 0; my = 0;
        prev_stall = 0; drain_next = 0; hs_cnt = 0; drain_seen = 0;
        areset = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < NC; i++) seq[i] = 0;
        withhold = '0; rand_ready = 0; ready_fixed = 1;

        // Full-rate frame: latency and in-order throughput
        do_reset(3);
        first_v = -1;
        for (int k = 1; k <= 18; k++) begin
            cycle();
            if (out_valid && first_v < 0) first_v = k;
        end
        check("t1_first_valid_cycle", first_v, 3);
        check("t1_hs_count", hs_cnt, 16);

        // Core 1 withholds: output stalls after core 0, no skipping
        do_reset(3);
        withhold = 4'b0010;
        for (int k = 1; k <= 10; k++) cycle();
        check("t2_ready_full", in_ready[3:2], 0);
        check("t2_stalled", out_valid, 0);
        check("t2_hs_before", hs_cnt, 1);
        withhold = '0;
        for (int k = 11; k <= 40; k++) cycle();
        check("t2_hs_after", hs_cnt, 29);

        // Random backpressure, 64 pixels
        do_reset(3);
        rand_ready = 1;
        for (int k = 0; k < 2000 && hs_cnt < 64; k++) cycle();
        check("t3_hs_count", hs_cnt, 64);
        rand_ready = 0;

        // Two active cores
        do_reset(1);
        for (int k = 1; k <= 20; k++) cycle();
        check("t4_ready_hi_off", in_ready[3:2], 0);
        check("t4_hs_count", hs_cnt, 18);

        // Mid-frame change 3 -> 1 takes effect at frame boundary with one DRAIN cycle
        do_reset(3);
        for (int k = 0; k < 200 && hs_cnt < 5; k++) cycle();
        active_cores = 2'd1;
        for (int k = 0; k < 400 && hs_cnt < 40; k++) cycle();
        check("t5_hs_count", hs_cnt, 40);
        check("t5_drain_seen", drain_seen, 1);
        check("t5_ready_hi_off", in_ready[3:2], 0);

        // Reset with pixels buffered discards them
        do_reset(3);
        ready_fixed = 0;
        for (int k = 1; k <= 4; k++) cycle();
        check("t6_buffered_valid", out_valid, 1);
        check("t6_fifo_full", in_ready, 0);
        ready_fixed = 1;
        do_reset(3);
        for (int k = 1; k <= 20; k++) cycle();
        check("t6_hs_count", hs_cnt, 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
